soc_system_status_pio_irq: RTL

Parametrised Avalon-MM slave input port for sampling SoC status flags such as FIFO full/empty/level bits. It generalises the single-bit status read port to WIDTH bits and adds:
- an optional input synchroniser,
- per-bit edge capture with write-1-to-clear,
- a per-bit interrupt mask,
- a level interrupt output to the HPS/Nios IRQ fabric.

It sits in the Qsys/Platform Designer system between fabric status signals and the lightweight HPS-to-FPGA bridge.

---
 rtl/soc_system_pio_pkg.sv | 17 +
 rtl/soc_system_pio_sync.sv | 44 ++++
 rtl/soc_system_status_pio_irq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the SoC status PIO block.
//   - pio_addr_e : Avalon word addresses of the register map
//   - EDGE_*     : encodings of the EDGE_TYPE capture-mode parameter
package soc_system_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RSVD     = 2'd1,
    ADDR_IRQ_MASK = 2'd2,
    ADDR_EDGE_CAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_sync.sv
// WIDTH-wide, STAGES-deep flop synchroniser for asynchronous status inputs.
// STAGES = 0 turns the block into a plain wire (input already synchronous).
// Ports:
//   clk    in  1      sampling clock
//   reset  in  1      synchronous, active-high; clears every stage
//   d      in  WIDTH  raw inputs
//   q      out WIDTH  d delayed by STAGES clk cycles
module soc_system_pio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
      // Clock and reset have no load in the bypass form.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
    end else begin : g_chain
      logic [WIDTH-1:0] stage_reg [STAGES];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < STAGES; i++) begin
            stage_reg[i] <= '0;
          end
        end else begin
          stage_reg[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            stage_reg[i] <= stage_reg[i-1];
          end
        end
      end

      assign q = stage_reg[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/soc_system_status_pio_irq.sv
// Avalon-MM status input port with edge capture and a level interrupt.
// Samples WIDTH status flags (optionally synchronised), captures selected
// edges into a write-1-to-clear register, and raises irq when any captured
// bit is also enabled in IRQ_MASK.
// Ports:
//   clk         in  1      system clock, rising edge
//   reset       in  1      synchronous, active-high
//   address     in  2      word address (0 DATA, 1 rsvd, 2 IRQ_MASK, 3 EDGE_CAPTURE)
//   chipselect  in  1      Avalon select
//   write_n     in  1      active-low write strobe, qualified by chipselect
//   writedata   in  32     write data
//   in_port     in  WIDTH  status inputs
//   readdata    out 32     registered read data, latency 1
//   irq         out 1      registered level interrupt
module soc_system_status_pio_irq
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] PRIME_LAST = 2'(SYNC_STAGES);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] edge_cap_reg;
  logic [WIDTH-1:0] edge_cap_next;
  logic [WIDTH-1:0] event_vec;
  logic [WIDTH-1:0] clear_vec;
  logic [1:0]       prime_cnt_reg;
  logic             prime_done_reg;
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;
  logic             irq_reg;
  logic             wr_en;

  // Only writedata[WIDTH-1:0] is meaningful; the rest is deliberately ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  soc_system_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_q)
  );

  assign wr_en = chipselect & ~write_n;

  // Priming: the sync chain and prev_reg restart at 0 after reset, so an
  // input that is already high looks like a rising edge for exactly one
  // cycle, SYNC_STAGES cycles after reset. The counter walks 0..SYNC_STAGES
  // and the done flag lands one cycle later, covering that window.
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_cnt_reg  <= 2'd0;
      prime_done_reg <= 1'b0;
    end else if (!prime_done_reg) begin
      if (prime_cnt_reg == PRIME_LAST) begin
        prime_done_reg <= 1'b1;
      end else begin
        prime_cnt_reg <= prime_cnt_reg + 2'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic rise;
      logic fall;
      assign rise = sync_q[gi] & ~prev_reg[gi];
      assign fall = ~sync_q[gi] & prev_reg[gi];
      assign event_vec[gi] = prime_done_reg &
                             ((EDGE_TYPE == EDGE_RISE) ? rise :
                              (EDGE_TYPE == EDGE_FALL) ? fall : (rise | fall));
    end
  endgenerate

  assign clear_vec = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
  // Set term is OR-ed after the clear so a coincident event wins.
  assign edge_cap_next = (edge_cap_reg & ~clear_vec) | event_vec;

  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA:     readdata_next[WIDTH-1:0] = sync_q;
      ADDR_IRQ_MASK: readdata_next[WIDTH-1:0] = irq_mask_reg;
      ADDR_EDGE_CAP: readdata_next[WIDTH-1:0] = edge_cap_reg;
      default:       readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg     <= '0;
      irq_mask_reg <= RESET_MASK;
      edge_cap_reg <= '0;
      readdata_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      prev_reg     <= sync_q;
      edge_cap_reg <= edge_cap_next;
      readdata_reg <= readdata_next;
      irq_reg      <= |(edge_cap_reg & irq_mask_reg);
      if (wr_en && address == ADDR_IRQ_MASK) begin
        irq_mask_reg <= writedata[WIDTH-1:0];
      end
    end
  end

  assign readdata = readdata_reg;
  assign irq      = irq_reg;

endmodule
